// File: rtl/pipeline_debug_ctrl.sv
// Byte-command debug controller for the MIPS pipeline: loads instruction memory
// over a serial link, runs or single-steps the core, and reports PC/data back.
module pipeline_debug_ctrl #(
   parameter int                 INST_SZ    = 32,
   parameter int                 PC_SZ      = 32,
   parameter int                 MEM_SZ     = 10,
   parameter int                 BYTE_SZ    = 8,
   parameter logic [INST_SZ-1:0] HALT_INSTR = 32'hFFFF_FFFF
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [BYTE_SZ-1:0] i_rx_data,
   input  logic               i_rx_valid,
   input  logic               i_tx_done,
   input  logic [PC_SZ-1:0]   i_pc,
   input  logic [INST_SZ-1:0] i_data,
   input  logic               i_halt,
   output logic [BYTE_SZ-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_write,
   output logic [INST_SZ-1:0] o_instruction,
   output logic               o_enable,
   output logic               o_busy
);

   localparam int INST_BYTES = INST_SZ / BYTE_SZ;
   localparam int PC_BYTES   = PC_SZ / BYTE_SZ;
   localparam int TX_BYTES   = PC_BYTES + INST_BYTES;
   localparam int SNAP_SZ    = PC_SZ + INST_SZ;
   localparam int BCW        = (INST_BYTES > 1) ? $clog2(INST_BYTES) : 1;
   localparam int TIW        = $clog2(TX_BYTES + 1);
   localparam int LCW        = MEM_SZ + 1;
   localparam int LOAD_MAX   = 2 ** MEM_SZ;

   localparam logic [BYTE_SZ-1:0] CMD_LOAD   = BYTE_SZ'(8'h4C);
   localparam logic [BYTE_SZ-1:0] CMD_RUN    = BYTE_SZ'(8'h43);
   localparam logic [BYTE_SZ-1:0] CMD_STEP   = BYTE_SZ'(8'h53);
   localparam logic [BYTE_SZ-1:0] CMD_REPORT = BYTE_SZ'(8'h52);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      RUN,
      STEP,
      REPORT_LOAD,
      REPORT_TX,
      REPORT_WAIT
   } state_t;

   state_t                    state_reg;
   state_t                    state_next;
   logic [BCW-1:0]            byte_cnt_reg;
   logic [INST_SZ-BYTE_SZ-1:0] word_reg;
   logic [INST_SZ-1:0]        instr_reg;
   logic                      write_reg;
   logic [LCW-1:0]            load_cnt_reg;
   logic                      enable_reg;
   logic [SNAP_SZ-1:0]        snap_reg;
   logic [TIW-1:0]            tx_idx_reg;

   logic load_done;
   logic rx_load_byte;
   logic word_last;
   logic tx_last;
   logic load_cmd;

   // The session ends in the write cycle itself, so o_busy drops one cycle after it.
   assign load_done    = write_reg &&
                         ((instr_reg == HALT_INSTR) ||
                          (load_cnt_reg == LCW'(LOAD_MAX - 1)));
   assign rx_load_byte = (state_reg == LOAD) && i_rx_valid && !load_done;
   assign word_last    = (byte_cnt_reg == BCW'(INST_BYTES - 1));
   assign tx_last      = (tx_idx_reg == TIW'(TX_BYTES - 1));
   assign load_cmd     = (state_reg == IDLE) && i_rx_valid && (i_rx_data == CMD_LOAD);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (i_rx_valid) begin
               case (i_rx_data)
                  CMD_LOAD:   state_next = LOAD;
                  CMD_RUN:    state_next = RUN;
                  CMD_STEP:   state_next = STEP;
                  CMD_REPORT: state_next = REPORT_LOAD;
                  default:    state_next = IDLE;
               endcase
            end
         end
         LOAD: begin
            if (load_done) begin
               state_next = IDLE;
            end
         end
         RUN: begin
            if (i_halt) begin
               state_next = REPORT_LOAD;
            end
         end
         STEP:        state_next = REPORT_LOAD;
         REPORT_LOAD: state_next = REPORT_TX;
         REPORT_TX:   state_next = REPORT_WAIT;
         REPORT_WAIT: begin
            if (i_tx_done) begin
               state_next = tx_last ? IDLE : REPORT_TX;
            end
         end
         default:     state_next = IDLE;
      endcase
   end

   // Instruction assembly and memory write strobe.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         byte_cnt_reg <= '0;
         word_reg     <= '0;
         instr_reg    <= '0;
         write_reg    <= 1'b0;
         load_cnt_reg <= '0;
      end else begin
         write_reg <= 1'b0;
         if (load_cmd) begin
            byte_cnt_reg <= '0;
            load_cnt_reg <= '0;
         end
         if (rx_load_byte) begin
            if (word_last) begin
               instr_reg    <= {word_reg, i_rx_data};
               write_reg    <= 1'b1;
               byte_cnt_reg <= '0;
            end else begin
               word_reg     <= {word_reg[INST_SZ-2*BYTE_SZ-1:0], i_rx_data};
               byte_cnt_reg <= byte_cnt_reg + 1'b1;
            end
         end
         if (write_reg) begin
            load_cnt_reg <= load_cnt_reg + 1'b1;
         end
      end
   end

   // STEP lasts one cycle, so this register yields a single enable pulse there.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         enable_reg <= 1'b0;
      end else begin
         enable_reg <= (state_next == RUN) || (state_next == STEP);
      end
   end

   // Snapshot is shifted left per finished byte; the outgoing byte is always the top one.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         snap_reg   <= '0;
         tx_idx_reg <= '0;
      end else begin
         if (state_reg == REPORT_LOAD) begin
            snap_reg   <= {i_pc, i_data};
            tx_idx_reg <= '0;
         end else if ((state_reg == REPORT_WAIT) && i_tx_done) begin
            snap_reg   <= snap_reg << BYTE_SZ;
            tx_idx_reg <= tx_idx_reg + 1'b1;
         end
      end
   end

   assign o_tx_data     = snap_reg[SNAP_SZ-1 -: BYTE_SZ];
   assign o_tx_start    = (state_reg == REPORT_TX);
   assign o_write       = write_reg;
   assign o_instruction = instr_reg;
   assign o_enable      = enable_reg && !i_halt;
   assign o_busy        = (state_reg != IDLE);

endmodule
